fifo_rd_arbiter: RTL and testbench

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

---
 rtl/tx_fifo_pkg.sv | 10 +
 rtl/rr_pick.sv | 21 ++
 rtl/fifo_rd_arbiter.sv | 73 +++++++
 tb/tb_fifo_rd_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared FSM encoding and width helper for the FIFO read arbiter
package tx_fifo_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first requesting index at or after start, wrapping at N
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] j;
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(start) + k) % N);
            if (req[j]) idx = j;
        end
        any = |req;
    end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst reader draining NUM_SRC show-ahead FIFOs into one registered stream
module fifo_rd_arbiter
    import tx_fifo_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int SW = clog2(NUM_SRC),
    localparam int CW = clog2(MAX_BURST + 1)
) (
    input  logic                          r_clk,
    input  logic                          rrst,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            rempty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] rdata,
    output logic [NUM_SRC-1:0]            rinc,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SW-1:0]                 out_src,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);
    state_t state, state_nx;
    logic [SW-1:0] grant, last_grant, pick, start;
    logic [CW-1:0] burst_cnt;
    logic any, pop, leave;

    assign start = (last_grant == SW'(NUM_SRC - 1)) ? '0 : last_grant + 1'b1;

    rr_pick #(.N(NUM_SRC), .W(SW)) u_pick (
        .req   (~rempty),
        .start (start),
        .idx   (pick),
        .any   (any)
    );

    // a pop is suppressed while reset is asserted so no FIFO word is lost to the flush
    always_comb begin
        pop = !rrst && state == BURST && enable && !rempty[grant] && (!out_valid || out_ready);
        leave = state == BURST && (!enable || rempty[grant] || (pop && burst_cnt == CW'(MAX_BURST - 1)));
        state_nx = (state == IDLE) ? ((enable && any) ? BURST : IDLE) : (leave ? IDLE : BURST);
        rinc = '0;
        rinc[grant] = pop;
        busy = state == BURST;
    end

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SW'(NUM_SRC - 1);
            burst_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && enable && any) begin
                grant     <= pick;
                burst_cnt <= '0;
            end
            if (pop) burst_cnt <= burst_cnt + 1'b1;
            if (leave) last_grant <= grant;
            if (pop) begin
                out_data  <= rdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                out_src   <= grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed scenarios against a counting FIFO model and output scoreboard
module tb_fifo_rd_arbiter;
    logic         r_clk, rrst, enable, out_ready, out_valid, busy;
    logic [3:0]   rempty, rinc;
    logic [127:0] rdata;
    logic [31:0]  out_data;
    logic [1:0]   out_src;

    fifo_rd_arbiter dut (
        .r_clk(r_clk), .rrst(rrst), .enable(enable), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    typedef struct {
        int cnt[4];
        int seq[16];
        int len;
        int gap_at;
        int gap;
    } vec_t;

    vec_t tv[4];
    int checks = 0, errors = 0;
    int cnt[4], rd_idx[4];
    int pops, delivered, cyc;
    int pop_src[$], pop_cyc[$];
    logic [31:0] exp_data[$];
    int exp_src[$];

    function automatic logic [31:0] word(input int s, input int k);
        return 32'(s * 4096 + k + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < 4; i++) begin
            rempty[i] = (cnt[i] == 0);
            rdata[i*32 +: 32] = word(i, rd_idx[i]);
        end
    endtask

    task automatic step();
        logic [3:0] pend;
        logic rst_now;
        @(negedge r_clk);
        chk("rinc_onehot", 32'($onehot0(rinc)), 1);
        chk("rinc_on_empty", 32'(rinc & rempty), 0);
        if (out_valid && out_ready && !rrst) begin
            chk("sb_nonempty", 32'(exp_data.size() != 0), 1);
            if (exp_data.size() != 0) begin
                chk("out_data", out_data, exp_data.pop_front());
                chk("out_src", 32'(out_src), exp_src.pop_front());
                delivered++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rinc[i]) begin
                exp_data.push_back(word(i, rd_idx[i]));
                exp_src.push_back(i);
                pop_src.push_back(i);
                pop_cyc.push_back(cyc);
                pops++;
            end
        end
        cyc++;
        pend = rinc;
        rst_now = rrst;
        @(posedge r_clk);
        #1;
        if (rst_now) begin
            exp_data.delete();
            exp_src.delete();
        end
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                cnt[i]--;
                rd_idx[i]++;
            end
        end
        drive_fifos();
    endtask

    task automatic reset_dut();
        rrst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            rd_idx[i] = 0;
        end
        drive_fifos();
        step();
        rrst = 1'b0;
        pops = 0;
        delivered = 0;
        cyc = 0;
        pop_src.delete();
        pop_cyc.delete();
    endtask

    task automatic run_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            step();
            n++;
        end
        if (pops < target) chk("pop_timeout", pops, target);
    endtask

    function automatic bit work_left();
        return (cnt[0] + cnt[1] + cnt[2] + cnt[3] != 0) || out_valid || busy;
    endfunction

    task automatic run_done(input int budget);
        int n = 0;
        while (work_left() && n < budget) begin
            step();
            n++;
        end
        if (work_left()) chk("done_timeout", 1, 0);
    endtask

    initial begin
        tv[0].cnt = '{6, 0, 6, 0};
        tv[0].seq = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2, 0, 0, 0, 0};
        tv[0].len = 12; tv[0].gap_at = 4; tv[0].gap = 2;
        tv[1].cnt = '{0, 2, 0, 0};
        tv[1].seq = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1].len = 2; tv[1].gap_at = 0; tv[1].gap = 0;
        tv[2].cnt = '{1, 1, 1, 1};
        tv[2].seq = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[2].len = 4; tv[2].gap_at = 1; tv[2].gap = 3;
        tv[3].cnt = '{5, 0, 0, 3};
        tv[3].seq = '{0, 0, 0, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[3].len = 8; tv[3].gap_at = 4; tv[3].gap = 2;

        // reset values while a source is already non-empty
        rrst = 1'b1; enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; rd_idx[i] = 0; end
        cnt[0] = 3;
        drive_fifos();
        pops = 0; delivered = 0; cyc = 0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", 32'(out_src), 0);

        for (int v = 0; v < 4; v++) begin
            int total;
            reset_dut();
            total = 0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] = tv[v].cnt[i];
                total += tv[v].cnt[i];
            end
            drive_fifos();
            run_done(300);
            chk("seq_len", pops, tv[v].len);
            for (int k = 0; k < tv[v].len; k++) chk("seq_src", pop_src[k], tv[v].seq[k]);
            if (tv[v].gap_at > 0) chk("switch_gap", pop_cyc[tv[v].gap_at] - pop_cyc[tv[v].gap_at - 1], tv[v].gap);
            chk("seq_delivered", delivered, total);
        end

        // downstream stall mid-burst
        reset_dut();
        cnt[0] = 4;
        drive_fifos();
        run_pops(2, 20);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_no_pop", pops, 2);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", out_data, word(0, 1));
        end
        out_ready = 1'b1;
        run_done(50);
        chk("stall_pops", pops, 4);
        chk("stall_delivered", delivered, 4);

        // enable dropped after the second beat
        reset_dut();
        cnt[2] = 5;
        drive_fifos();
        run_pops(2, 20);
        enable = 1'b0;
        out_ready = 1'b0;
        step();
        chk("en_idle", 32'(busy), 0);
        chk("en_held_valid", 32'(out_valid), 1);
        chk("en_held_data", out_data, word(2, 1));
        for (int k = 0; k < 4; k++) step();
        chk("en_no_pop", pops, 2);
        out_ready = 1'b1;
        step();
        chk("en_drained", 32'(out_valid), 0);
        chk("en_delivered", delivered, 2);
        enable = 1'b1;
        run_done(50);
        chk("en_pops", pops, 5);
        chk("en_all_delivered", delivered, 5);

        // 20 bursts with every source busy
        reset_dut();
        for (int i = 0; i < 4; i++) cnt[i] = 20;
        drive_fifos();
        run_done(400);
        chk("rr_pops", pops, 80);
        for (int b = 0; b < 20; b++) chk("rr_order", pop_src[b*4], b % 4);

        // reset mid-burst with a word held
        reset_dut();
        cnt[1] = 4;
        drive_fifos();
        run_pops(2, 20);
        chk("mid_valid", 32'(out_valid), 1);
        rrst = 1'b1;
        cnt[0] = 2;
        drive_fifos();
        step();
        rrst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rinc", 32'(rinc), 0);
        chk("mid_rst_pops", pops, 2);
        run_pops(3, 10);
        chk("mid_first_grant", pop_src[2], 0);
        run_done(50);
        chk("mid_total_pops", pops, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
